// File: rtl/ecs3_pkg.sv
// Shared ECS3 link definitions: receiver state encoding and link defaults.
package ecs3_pkg;
   localparam int   ECS3_OVERSAMPLE = 4;
   localparam int   ECS3_DATA_BITS  = 8;
   localparam logic ECS3_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rxState_t;
endpackage

// File: rtl/ecs3_serial_rx_if.sv
// Receiver-side bundle: serial line in, recovered byte and status out.
interface ecs3_serial_rx_if
   import ecs3_pkg::*;
#(
   parameter int DATA_BITS = ECS3_DATA_BITS
);
   logic                 rxIn;
   logic [DATA_BITS-1:0] rxData;
   logic                 rxValid;
   logic                 rxFrameErr;
   logic                 rxBusy;

   modport master (input rxIn, output rxData, rxValid, rxFrameErr, rxBusy);
   modport slave  (output rxIn, input rxData, rxValid, rxFrameErr, rxBusy);
endinterface

// File: rtl/ecs3_sync2.sv
// Generic two-flop synchroniser; RESET_VAL sets the value both flops take in reset.
module ecs3_sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic nRST,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/ecs3_serial_rx.sv
// ECS3 serial frame receiver: oversampled start/data/stop recovery, LSB first.
// Emits a one-cycle rxValid per good frame, or rxFrameErr when the stop bit is low.
module ecs3_serial_rx
   import ecs3_pkg::*;
#(
   parameter int OVERSAMPLE = ECS3_OVERSAMPLE,
   parameter int DATA_BITS  = ECS3_DATA_BITS
) (
   input  logic             clk,
   input  logic             nRST,
   ecs3_serial_rx_if.master rx
);
   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   rxState_t             state, stateNext;
   logic [CNT_W-1:0]     cnt, cntNext;
   logic [IDX_W-1:0]     idx, idxNext;
   logic [DATA_BITS-1:0] shReg, shNext;
   logic [DATA_BITS-1:0] dataReg, dataNext;
   logic                 validReg, validNext;
   logic                 ferrReg, ferrNext;
   logic                 rxS;

   ecs3_sync2 #(.RESET_VAL(ECS3_IDLE_LEVEL)) uSync (
      .clk  (clk),
      .nRST (nRST),
      .d    (rx.rxIn),
      .q    (rxS)
   );

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state    <= RX_IDLE;
         cnt      <= '0;
         idx      <= '0;
         shReg    <= '0;
         dataReg  <= '0;
         validReg <= 1'b0;
         ferrReg  <= 1'b0;
      end else begin
         state    <= stateNext;
         cnt      <= cntNext;
         idx      <= idxNext;
         shReg    <= shNext;
         dataReg  <= dataNext;
         validReg <= validNext;
         ferrReg  <= ferrNext;
      end
   end

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      idxNext   = idx;
      shNext    = shReg;
      dataNext  = dataReg;
      validNext = 1'b0;
      ferrNext  = 1'b0;
      case (state)
         RX_IDLE: begin
            if (rxS != ECS3_IDLE_LEVEL) begin
               stateNext = RX_START;
               cntNext   = '0;
            end
         end
         RX_START: begin
            // Start bit is re-checked mid-bit; a high line here was only a glitch.
            if (cnt == HALF_LAST) begin
               cntNext = '0;
               if (rxS != ECS3_IDLE_LEVEL) begin
                  stateNext = RX_DATA;
                  idxNext   = '0;
               end else begin
                  stateNext = RX_IDLE;
               end
            end else begin
               cntNext = cnt + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt == BIT_LAST) begin
               shNext[idx] = rxS;
               cntNext     = '0;
               if (idx == IDX_LAST) stateNext = RX_STOP;
               else                 idxNext   = idx + 1'b1;
            end else begin
               cntNext = cnt + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt == BIT_LAST) begin
               cntNext = '0;
               if (rxS == ECS3_IDLE_LEVEL) begin
                  dataNext  = shReg;
                  validNext = 1'b1;
                  stateNext = RX_IDLE;
               end else begin
                  ferrNext  = 1'b1;
                  stateNext = RX_BREAK;
               end
            end else begin
               cntNext = cnt + 1'b1;
            end
         end
         RX_BREAK: begin
            // Wait out a held-low line so it reports one error, not one per frame time.
            if (rxS == ECS3_IDLE_LEVEL) stateNext = RX_IDLE;
         end
         default: stateNext = RX_IDLE;
      endcase
   end

   assign rx.rxData     = dataReg;
   assign rx.rxValid    = validReg;
   assign rx.rxFrameErr = ferrReg;
   assign rx.rxBusy     = (state != RX_IDLE);
endmodule

// File: tb/tb_ecs3_serial_rx.sv
// Bench for ecs3_serial_rx: directed table, hand sequences and random line traffic
// checked cycle by cycle against a frame-decoding reference model.
module tb_ecs3_serial_rx;
   localparam int OS_A = 4;
   localparam int DB_A = 8;
   localparam int OS_B = 8;
   localparam int DB_B = 7;

   logic clk = 1'b0;
   logic nRST;
   always #5 clk = ~clk;

   ecs3_serial_rx_if #(.DATA_BITS(DB_A)) ifA ();
   ecs3_serial_rx_if #(.DATA_BITS(DB_B)) ifB ();

   ecs3_serial_rx #(.OVERSAMPLE(OS_A), .DATA_BITS(DB_A)) dutA (
      .clk (clk), .nRST (nRST), .rx (ifA.master));
   ecs3_serial_rx #(.OVERSAMPLE(OS_B), .DATA_BITS(DB_B)) dutB (
      .clk (clk), .nRST (nRST), .rx (ifB.master));

   int nTests = 0;
   int nFail  = 0;

   // wave[i] is the line level captured by the first synchroniser flop at edge i of a run
   bit         wave[$];
   logic [8:0] lastData[2];
   int         rVcnt, rEcnt, rFirstV, rBusy;
   logic [8:0] rData;
   int         vEdges[$];
   logic [8:0] vDatas[$];

   typedef struct {
      int         sel;      // 0: OS=4/DB=8 unit, 1: OS=8/DB=7 unit
      int         kind;     // 0: frame, 1: low glitch of lowHold cycles
      logic [8:0] data;
      bit         stopBit;
      int         lowHold;  // extra low cycles after the frame, or glitch length
      int         expV;
      int         expE;
      logic [8:0] expData;
      int         expOff;   // edge of first rxValid relative to E, -1 if none
      int         expBusy;  // busy cycle count, -1 to skip
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int osOf(input int sel);
      return (sel == 0) ? OS_A : OS_B;
   endfunction

   function automatic int dbOf(input int sel);
      return (sel == 0) ? DB_A : DB_B;
   endfunction

   task automatic setLine(input int sel, input bit v);
      if (sel == 0) ifA.rxIn = v;
      else          ifB.rxIn = v;
   endtask

   task automatic sampleOut(input int sel, output bit v, output bit e, output bit b,
                            output logic [8:0] d);
      if (sel == 0) begin
         v = ifA.rxValid; e = ifA.rxFrameErr; b = ifA.rxBusy; d = 9'(ifA.rxData);
      end else begin
         v = ifB.rxValid; e = ifB.rxFrameErr; b = ifB.rxBusy; d = 9'(ifB.rxData);
      end
   endtask

   task automatic pushIdle(input int n);
      for (int i = 0; i < n; i++) wave.push_back(1'b1);
   endtask

   task automatic pushLow(input int n);
      for (int i = 0; i < n; i++) wave.push_back(1'b0);
   endtask

   task automatic pushFrame(input int sel, input logic [8:0] data, input bit stopBit);
      pushLow(osOf(sel));
      for (int k = 0; k < dbOf(sel); k++)
         for (int j = 0; j < osOf(sel); j++) wave.push_back(data[k]);
      for (int j = 0; j < osOf(sel); j++) wave.push_back(stopBit);
   endtask

   // Synchronised line level seen by the receiver at edge c (two edges of delay, idle before).
   function automatic bit rs(input int c);
      if (c < 2 || c - 2 >= wave.size()) return 1'b1;
      return wave[c-2];
   endfunction

   // Decode the waveform with the frame timing rules, then drive it and compare every cycle.
   task automatic runWave(input int sel);
      int os, db, n, c, st, sp, b;
      bit expV[], expE[], expB[];
      logic [8:0] expD[], dataAt[];
      logic [8:0] val, d, ad;
      bit v, e, bz;
      os = osOf(sel);
      db = dbOf(sel);
      n  = wave.size();
      expV = new[n]; expE = new[n]; expB = new[n]; expD = new[n]; dataAt = new[n];
      for (int i = 0; i < n; i++) dataAt[i] = '0;
      c = 0;
      while (c < n) begin
         if (rs(c)) begin
            c++;
         end else begin
            st = c + os / 2;
            if (rs(st)) begin
               for (int i = c; i < st && i < n; i++) expB[i] = 1'b1;
               c = st + 1;
            end else begin
               val = '0;
               for (int k = 0; k < db; k++) val[k] = rs(st + os * (k + 1));
               sp = st + os * (db + 1);
               if (rs(sp)) begin
                  for (int i = c; i < sp && i < n; i++) expB[i] = 1'b1;
                  if (sp < n) begin expV[sp] = 1'b1; dataAt[sp] = val; end
                  c = sp + 1;
               end else begin
                  b = sp + 1;
                  while (!rs(b)) b++;
                  for (int i = c; i < b && i < n; i++) expB[i] = 1'b1;
                  if (sp < n) expE[sp] = 1'b1;
                  c = b + 1;
               end
            end
         end
      end
      d = lastData[sel];
      for (int i = 0; i < n; i++) begin
         if (expV[i]) d = dataAt[i];
         expD[i] = d;
      end
      lastData[sel] = d;

      rVcnt = 0; rEcnt = 0; rFirstV = -1; rBusy = 0; ad = '0;
      vEdges.delete(); vDatas.delete();
      for (int i = 0; i < n; i++) begin
         setLine(sel, wave[i]);
         @(posedge clk);
         @(negedge clk);
         sampleOut(sel, v, e, bz, ad);
         if (v) begin
            rVcnt++;
            if (rFirstV < 0) rFirstV = i + 1;
            vEdges.push_back(i + 1);
            vDatas.push_back(ad);
         end
         if (e)  rEcnt++;
         if (bz) rBusy++;
         check($sformatf("u%0d cyc%0d {valid,ferr,busy,data}", sel, i),
               int'({v, e, bz, ad}), int'({expV[i], expE[i], expB[i], expD[i]}));
      end
      rData = ad;
      setLine(sel, 1'b1);
   endtask

   vec_t vecs[7];

   initial begin
      int e0, r, sel, os, db;
      logic [8:0] rd;
      bit v, e, bz;
      logic [8:0] ad;

      nRST = 1'b0;
      ifA.rxIn = 1'b1;
      ifB.rxIn = 1'b1;
      lastData[0] = '0;
      lastData[1] = '0;
      repeat (3) @(negedge clk);
      sampleOut(0, v, e, bz, ad);
      check("reset A outputs", int'({v, e, bz, ad}), 0);
      sampleOut(1, v, e, bz, ad);
      check("reset B outputs", int'({v, e, bz, ad}), 0);
      nRST = 1'b1;
      repeat (2) @(negedge clk);
      sampleOut(0, v, e, bz, ad);
      check("post-reset A idle", int'({v, e, bz, ad}), 0);

      vecs[0] = '{0, 0, 9'hA5, 1'b1, 0,  1, 0, 9'hA5, 41, 38};
      vecs[1] = '{0, 0, 9'h3C, 1'b0, 20, 0, 1, 9'hA5, -1, 60};
      vecs[2] = '{0, 0, 9'h11, 1'b1, 0,  1, 0, 9'h11, 41, -1};
      vecs[3] = '{0, 1, 9'h00, 1'b1, 1,  0, 0, 9'h11, -1, 2};
      vecs[4] = '{1, 0, 9'h6B, 1'b1, 0,  1, 0, 9'h6B, 71, -1};
      vecs[5] = '{1, 1, 9'h00, 1'b1, 3,  0, 0, 9'h6B, -1, 4};
      vecs[6] = '{0, 0, 9'h00, 1'b1, 0,  1, 0, 9'h00, 41, -1};

      foreach (vecs[i]) begin
         sel = vecs[i].sel;
         wave.delete();
         pushIdle(4);
         e0 = wave.size();
         if (vecs[i].kind == 0) begin
            pushFrame(sel, vecs[i].data, vecs[i].stopBit);
            pushLow(vecs[i].lowHold);
         end else begin
            pushLow(vecs[i].lowHold);
         end
         pushIdle(osOf(sel) * (dbOf(sel) + 3));
         runWave(sel);
         check($sformatf("vec%0d valid count", i), rVcnt, vecs[i].expV);
         check($sformatf("vec%0d ferr count", i), rEcnt, vecs[i].expE);
         check($sformatf("vec%0d rxData", i), int'(rData), int'(vecs[i].expData));
         check($sformatf("vec%0d valid edge", i), (rFirstV < 0) ? -1 : rFirstV - e0,
               vecs[i].expOff);
         if (vecs[i].expBusy >= 0)
            check($sformatf("vec%0d busy cycles", i), rBusy, vecs[i].expBusy);
      end

      // Back-to-back 0x00 then 0xFF with no idle gap
      wave.delete();
      pushIdle(4);
      e0 = wave.size();
      pushFrame(0, 9'h00, 1'b1);
      pushFrame(0, 9'hFF, 1'b1);
      pushIdle(OS_A * (DB_A + 3));
      runWave(0);
      check("b2b valid count", rVcnt, 2);
      check("b2b first edge", (vEdges.size() > 0) ? vEdges[0] - e0 : -1, 41);
      check("b2b spacing", (vEdges.size() > 1) ? vEdges[1] - vEdges[0] : -1, 40);
      check("b2b data0", (vDatas.size() > 0) ? int'(vDatas[0]) : -1, 'h00);
      check("b2b data1", (vDatas.size() > 1) ? int'(vDatas[1]) : -1, 'hFF);

      // Reset during data bit 3 of 0xF8: bits 3..7 and stop are high, so nothing follows
      wave.delete();
      pushIdle(4);
      pushFrame(0, 9'hF8, 1'b1);
      for (int i = 0; i <= 20; i++) begin
         setLine(0, wave[i]);
         @(posedge clk);
         @(negedge clk);
      end
      nRST = 1'b0;
      #1;
      sampleOut(0, v, e, bz, ad);
      check("mid-frame reset outputs", int'({v, e, bz, ad}), 0);
      for (int i = 21; i <= 22; i++) begin
         setLine(0, wave[i]);
         @(posedge clk);
         @(negedge clk);
      end
      nRST = 1'b1;
      lastData[0] = '0;
      lastData[1] = '0;
      wave.delete();
      pushIdle(21);
      e0 = wave.size();
      pushFrame(0, 9'h5A, 1'b1);
      pushIdle(OS_A * (DB_A + 3));
      runWave(0);
      check("post-reset valid count", rVcnt, 1);
      check("post-reset rxData", int'(rData), 'h5A);
      check("post-reset valid edge", (rFirstV < 0) ? -1 : rFirstV - e0, 41);

      // Random traffic: frames, framing errors with held-low lines, glitches
      for (int it = 0; it < 40; it++) begin
         sel = it % 2;
         os  = osOf(sel);
         db  = dbOf(sel);
         wave.delete();
         pushIdle($urandom_range(2, 6));
         for (int k = 0; k < 3; k++) begin
            r  = $urandom_range(0, 9);
            rd = 9'($urandom_range(0, (1 << db) - 1));
            if (r < 6) begin
               pushFrame(sel, rd, 1'b1);
            end else if (r < 8) begin
               pushFrame(sel, rd, 1'b0);
               pushLow($urandom_range(0, 10));
               pushIdle($urandom_range(1, 3));
            end else begin
               pushLow($urandom_range(1, os));
            end
            pushIdle($urandom_range(0, 3));
         end
         pushIdle(os * (db + 3));
         runWave(sel);
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
